// File: rtl/dcache_pkg.sv
// Shared types and width helpers for the direct-mapped data cache.
package dcache_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0]   word_t;
    typedef logic [WORD_W/8-1:0] lane_mask_t;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WRITEBACK  = 3'd1,
        S_REFILL     = 3'd2,
        S_FLUSH_SCAN = 3'd3,
        S_FLUSH_WB   = 3'd4
    } state_e;

    function automatic int idx_w(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int tag_w(input int addr_w, input int lines);
        return addr_w - $clog2(lines) - 2;
    endfunction

    // Word stores touch all four lanes; byte stores touch the lane named by addr[1:0].
    function automatic lane_mask_t lane_mask(input logic is_word, input logic [1:0] lane);
        lane_mask_t m;
        if (is_word) begin
            m = '1;
        end else begin
            m = lane_mask_t'(1) << lane;
        end
        return m;
    endfunction

endpackage

// File: rtl/dcache_if.sv
// CPU-side, memory-side and flush signals of the data cache; slave is the cache view.
interface dcache_if #(
    parameter int ADDR_W = 32
);
    logic                cpu_req;
    logic                cpu_we;
    logic                cpu_is_word;
    logic [ADDR_W-1:0]   cpu_addr;
    dcache_pkg::word_t   cpu_wdata;
    dcache_pkg::word_t   cpu_rdata;
    logic                cpu_stall;

    logic                mem_req;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    dcache_pkg::word_t   mem_wdata;
    dcache_pkg::word_t   mem_rdata;
    logic                mem_ack;

    logic                flush_req;
    logic                flush_done;

    modport slave (
        input  cpu_req, cpu_we, cpu_is_word, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_stall,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack,
        input  flush_req,
        output flush_done
    );

    modport master (
        output cpu_req, cpu_we, cpu_is_word, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_stall,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack,
        output flush_req,
        input  flush_done
    );
endinterface

// File: rtl/dcache_array.sv
// Tag/valid/dirty/data storage: one combinational read port, one byte-masked write port.
module dcache_array
    import dcache_pkg::*;
#(
    parameter  int LINES  = 16,
    parameter  int ADDR_W = 32,
    localparam int IDX_W  = idx_w(LINES),
    localparam int TAG_W  = tag_w(ADDR_W, LINES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_valid,
    output logic             rd_dirty,
    output logic [TAG_W-1:0] rd_tag,
    output word_t            rd_data,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  lane_mask_t       wr_be,
    input  word_t            wr_data,
    input  logic             wr_tag_en,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic             wr_valid,
    input  logic             wr_dirty
);
    logic [LINES-1:0] valid_q, valid_d;
    logic [LINES-1:0] dirty_q, dirty_d;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [TAG_W-1:0] tag_d  [LINES];
    word_t            data_q [LINES];
    word_t            data_d [LINES];

    assign rd_valid = valid_q[rd_idx];
    assign rd_dirty = dirty_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_data  = data_q[rd_idx];

    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (wr_en) begin
            valid_d[wr_idx] = wr_valid;
            dirty_d[wr_idx] = wr_dirty;
            if (wr_tag_en) begin
                tag_d[wr_idx] = wr_tag;
            end
            for (int k = 0; k < WORD_W / 8; k++) begin
                if (wr_be[k]) begin
                    data_d[wr_idx][8*k +: 8] = wr_data[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Payload arrays keep their contents across reset; only the valid bits matter.
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

endmodule

// File: rtl/dcache_unit.sv
// Direct-mapped write-back data cache (one word per line) with halt-time flush.
// Defining DCACHE_STATS_EN adds the hit_count/miss_count outputs.
module dcache_unit
    import dcache_pkg::*;
#(
    parameter int LINES  = 16,
    parameter int ADDR_W = 32
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef DCACHE_STATS_EN
    output logic [31:0] hit_count,
    output logic [31:0] miss_count,
`endif
    dcache_if.slave     bus
);
    localparam int IDX_W = idx_w(LINES);
    localparam int TAG_W = tag_w(ADDR_W, LINES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINES - 1);

    localparam logic [2:0] IDLE       = S_IDLE;
    localparam logic [2:0] WRITEBACK  = S_WRITEBACK;
    localparam logic [2:0] REFILL     = S_REFILL;
    localparam logic [2:0] FLUSH_SCAN = S_FLUSH_SCAN;
    localparam logic [2:0] FLUSH_WB   = S_FLUSH_WB;

    logic [2:0]        state_q, state_d;
    logic [TAG_W-1:0]  miss_tag_q, miss_tag_d;
    logic [IDX_W-1:0]  miss_idx_q, miss_idx_d;
    logic [IDX_W-1:0]  scan_q, scan_d;
    logic              flush_done_q, flush_done_d;

    logic [TAG_W-1:0]  cpu_tag;
    logic [IDX_W-1:0]  cpu_idx;
    logic [1:0]        cpu_lane;

    logic [IDX_W-1:0]  rd_idx;
    logic              rd_valid;
    logic              rd_dirty;
    logic [TAG_W-1:0]  rd_tag;
    word_t             rd_data;

    logic              wr_en;
    lane_mask_t        wr_be;
    word_t             wr_data;
    logic              wr_tag_en;
    logic              wr_valid;
    logic              wr_dirty;

    logic              hit;
    logic              stall;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    word_t             mem_wdata;
    logic              req_out;
    word_t             load_data;

    assign cpu_tag  = bus.cpu_addr[ADDR_W-1:IDX_W+2];
    assign cpu_idx  = bus.cpu_addr[IDX_W+1:2];
    assign cpu_lane = bus.cpu_addr[1:0];

    // The single read port follows whichever line the current state is working on.
    always_comb begin
        case (state_q)
            IDLE:              rd_idx = cpu_idx;
            WRITEBACK, REFILL: rd_idx = miss_idx_q;
            default:           rd_idx = scan_q;
        endcase
    end

    assign hit = rd_valid && (rd_tag == cpu_tag);

    dcache_array #(
        .LINES  (LINES),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_idx    (rd_idx),
        .rd_valid  (rd_valid),
        .rd_dirty  (rd_dirty),
        .rd_tag    (rd_tag),
        .rd_data   (rd_data),
        .wr_en     (wr_en),
        .wr_idx    (rd_idx),
        .wr_be     (wr_be),
        .wr_data   (wr_data),
        .wr_tag_en (wr_tag_en),
        .wr_tag    (miss_tag_q),
        .wr_valid  (wr_valid),
        .wr_dirty  (wr_dirty)
    );

    always_comb begin
        state_d      = state_q;
        miss_tag_d   = miss_tag_q;
        miss_idx_d   = miss_idx_q;
        scan_d       = scan_q;
        flush_done_d = flush_done_q;
        wr_en        = 1'b0;
        wr_be        = '0;
        wr_data      = '0;
        wr_tag_en    = 1'b0;
        wr_valid     = rd_valid;
        wr_dirty     = rd_dirty;
        stall        = 1'b1;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;

        case (state_q)
            IDLE: begin
                stall = 1'b0;
                if (bus.flush_req) begin
                    stall   = bus.cpu_req;
                    scan_d  = '0;
                    state_d = FLUSH_SCAN;
                end else if (bus.cpu_req) begin
                    if (hit) begin
                        if (bus.cpu_we) begin
                            wr_en        = 1'b1;
                            wr_be        = lane_mask(bus.cpu_is_word, cpu_lane);
                            wr_data      = bus.cpu_is_word ? bus.cpu_wdata : {4{bus.cpu_wdata[7:0]}};
                            wr_valid     = 1'b1;
                            wr_dirty     = 1'b1;
                            flush_done_d = 1'b0;
                        end
                    end else begin
                        stall      = 1'b1;
                        miss_tag_d = cpu_tag;
                        miss_idx_d = cpu_idx;
                        state_d    = (rd_valid && rd_dirty) ? WRITEBACK : REFILL;
                    end
                end
            end
            WRITEBACK: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {rd_tag, miss_idx_q, 2'b00};
                mem_wdata = rd_data;
                if (bus.mem_ack) begin
                    state_d = REFILL;
                end
            end
            REFILL: begin
                mem_req  = 1'b1;
                mem_addr = {miss_tag_q, miss_idx_q, 2'b00};
                if (bus.mem_ack) begin
                    wr_en     = 1'b1;
                    wr_be     = '1;
                    wr_data   = bus.mem_rdata;
                    wr_tag_en = 1'b1;
                    wr_valid  = 1'b1;
                    wr_dirty  = 1'b0;
                    state_d   = IDLE;
                end
            end
            FLUSH_SCAN: begin
                if (rd_valid && rd_dirty) begin
                    state_d = FLUSH_WB;
                end else if (scan_q == LAST_IDX) begin
                    scan_d       = '0;
                    flush_done_d = 1'b1;
                    state_d      = IDLE;
                end else begin
                    scan_d = scan_q + 1'b1;
                end
            end
            FLUSH_WB: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {rd_tag, scan_q, 2'b00};
                mem_wdata = rd_data;
                if (bus.mem_ack) begin
                    wr_en    = 1'b1;
                    wr_dirty = 1'b0;
                    if (scan_q == LAST_IDX) begin
                        scan_d       = '0;
                        flush_done_d = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        scan_d  = scan_q + 1'b1;
                        state_d = FLUSH_SCAN;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            miss_tag_q   <= '0;
            miss_idx_q   <= '0;
            scan_q       <= '0;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            miss_tag_q   <= miss_tag_d;
            miss_idx_q   <= miss_idx_d;
            scan_q       <= scan_d;
            flush_done_q <= flush_done_d;
        end
    end

    always_comb begin
        if (bus.cpu_is_word) begin
            load_data = rd_data;
        end else begin
            load_data = {24'b0, rd_data[{cpu_lane, 3'b000} +: 8]};
        end
    end

    // Reset forces the handshake outputs low immediately, without waiting for a clock.
    assign req_out        = rst_n & mem_req;
    assign bus.cpu_rdata  = load_data;
    assign bus.cpu_stall  = rst_n & stall;
    assign bus.mem_req    = req_out;
    assign bus.mem_we     = req_out & mem_we;
    assign bus.mem_addr   = req_out ? mem_addr : '0;
    assign bus.mem_wdata  = req_out ? mem_wdata : '0;
    assign bus.flush_done = flush_done_q;

`ifdef DCACHE_STATS_EN
    logic        acc_hit;
    logic        acc_miss;
    logic [31:0] hit_count_q, hit_count_d;
    logic [31:0] miss_count_q, miss_count_d;

    assign acc_hit  = (state_q == IDLE) && bus.cpu_req && !bus.flush_req && hit;
    assign acc_miss = (state_q == IDLE) && ((state_d == WRITEBACK) || (state_d == REFILL));

    always_comb begin
        hit_count_d  = hit_count_q + 32'(acc_hit);
        miss_count_d = miss_count_q + 32'(acc_miss);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_dcache_unit.sv
// Directed bench for dcache_unit: the bench plays CPU and memory with hand-computed expectations.
module tb_dcache_unit;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    dcache_if #(.ADDR_W(32)) bus ();

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    dcache_unit #(
        .LINES  (16),
        .ADDR_W (32)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef DCACHE_STATS_EN
        .hit_count  (hit_count),
        .miss_count (miss_count),
`endif
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "bench timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cpu(input logic req, input logic we, input logic word,
                           input logic [31:0] addr, input logic [31:0] wdata);
        bus.cpu_req     = req;
        bus.cpu_we      = we;
        bus.cpu_is_word = word;
        bus.cpu_addr    = addr;
        bus.cpu_wdata   = wdata;
    endtask

    // Wait (bounded) for a memory request, check it, then acknowledge it for one cycle.
    task automatic serve(input string tag, input logic we_exp, input logic [31:0] addr_exp,
                         input logic [31:0] wdata_exp, input logic [31:0] rdata);
        int n;
        n = 0;
        #1;
        while (!bus.mem_req && n < 8) begin
            tick();
            #1;
            n++;
        end
        chk({tag, "_req"}, 32'(bus.mem_req), 32'd1);
        chk({tag, "_we"}, 32'(bus.mem_we), 32'(we_exp));
        chk({tag, "_addr"}, bus.mem_addr, addr_exp);
        if (we_exp) chk({tag, "_wdata"}, bus.mem_wdata, wdata_exp);
        chk({tag, "_stall"}, 32'(bus.cpu_stall), 32'd1);
        bus.mem_rdata = rdata;
        bus.mem_ack   = 1'b1;
        tick();
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
    endtask

    logic [31:0] wa [4];
    logic [31:0] wd [4];
    int          nwr;
    bit          done;

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        set_cpu(1'b1, 1'b0, 1'b1, 32'h100, 32'h0);
        bus.mem_rdata = '0;
        bus.mem_ack   = 1'b0;
        bus.flush_req = 1'b0;

        // Reset state, with a request pending that would otherwise miss
        repeat (3) @(posedge clk);
        #1;
        chk("rst_stall", 32'(bus.cpu_stall), 32'd0);
        chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst_flush_done", 32'(bus.flush_done), 32'd0);
        set_cpu(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        rst_n = 1'b1;
        tick();

        // Byte store 0xAB to 0x5 on a cold cache
        set_cpu(1'b1, 1'b1, 1'b0, 32'h5, 32'hAB);
        #1;
        chk("A_miss_stall", 32'(bus.cpu_stall), 32'd1);
        chk("A_idle_mem_req", 32'(bus.mem_req), 32'd0);
        chk("A_idle_mem_addr", bus.mem_addr, 32'h0);
        tick();
        serve("A_refill", 1'b0, 32'h4, 32'h0, 32'h1122_3344);
        #1;
        chk("A_retry_stall", 32'(bus.cpu_stall), 32'd0);
        tick();
        set_cpu(1'b1, 1'b0, 1'b1, 32'h4, 32'h0);
        #1;
        chk("A_line_word", bus.cpu_rdata, 32'h1122_AB44);
        chk("A_hit_stall", 32'(bus.cpu_stall), 32'd0);
        tick();
        set_cpu(1'b1, 1'b0, 1'b0, 32'h5, 32'h0);
        #1;
        chk("A_lb5", bus.cpu_rdata, 32'h0000_00AB);
        tick();
        set_cpu(1'b1, 1'b0, 1'b0, 32'h7, 32'h0);
        #1;
        chk("A_lb7", bus.cpu_rdata, 32'h0000_0011);

        // Clean word-load miss on 0x40, then hits at 0x40 and 0x43
        tick();
        set_cpu(1'b1, 1'b0, 1'b1, 32'h40, 32'h0);
        #1;
        chk("B_miss_stall", 32'(bus.cpu_stall), 32'd1);
        tick();
        serve("B_refill", 1'b0, 32'h40, 32'h0, 32'hCAFE_0040);
        #1;
        chk("B_hit_stall", 32'(bus.cpu_stall), 32'd0);
        chk("B_hit_rdata", bus.cpu_rdata, 32'hCAFE_0040);
        tick();
        set_cpu(1'b1, 1'b0, 1'b1, 32'h43, 32'h0);
        #1;
        chk("B_lw3_rdata", bus.cpu_rdata, 32'hCAFE_0040);
        chk("B_lw3_stall", 32'(bus.cpu_stall), 32'd0);

        // Dirty 0x40, then load 0x80 on the same index: writeback before refill
        tick();
        set_cpu(1'b1, 1'b1, 1'b1, 32'h40, 32'h0BAD_F00D);
        #1;
        chk("C_store_stall", 32'(bus.cpu_stall), 32'd0);
        tick();
        set_cpu(1'b1, 1'b0, 1'b1, 32'h80, 32'h0);
        #1;
        chk("C_miss_stall", 32'(bus.cpu_stall), 32'd1);
        chk("C_miss_mem_req", 32'(bus.mem_req), 32'd0);
        tick();
        #1;
        chk("C_wb_req", 32'(bus.mem_req), 32'd1);
        chk("C_wb_we", 32'(bus.mem_we), 32'd1);
        chk("C_wb_addr", bus.mem_addr, 32'h40);
        chk("C_wb_wdata", bus.mem_wdata, 32'h0BAD_F00D);
        tick();
        set_cpu(1'b0, 1'b0, 1'b1, 32'h80, 32'h0);
        #1;
        chk("C_wb_hold_req", 32'(bus.mem_req), 32'd1);
        chk("C_wb_hold_addr", bus.mem_addr, 32'h40);
        chk("C_wb_hold_stall", 32'(bus.cpu_stall), 32'd1);
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        set_cpu(1'b1, 1'b0, 1'b1, 32'h80, 32'h0);
        serve("C_refill", 1'b0, 32'h80, 32'h0, 32'h8080_8080);
        #1;
        chk("C_hit_stall", 32'(bus.cpu_stall), 32'd0);
        chk("C_hit_rdata", bus.cpu_rdata, 32'h8080_8080);

        // Asynchronous reset in the middle of a refill
        tick();
        set_cpu(1'b1, 1'b0, 1'b1, 32'hC, 32'h0);
        #1;
        chk("E_miss_stall", 32'(bus.cpu_stall), 32'd1);
        tick();
        #1;
        chk("E_refill_req", 32'(bus.mem_req), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("E_rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("E_rst_stall", 32'(bus.cpu_stall), 32'd0);
        tick();
        rst_n = 1'b1;
        set_cpu(1'b1, 1'b0, 1'b1, 32'h80, 32'h0);
        #1;
        chk("E_post_rst_miss", 32'(bus.cpu_stall), 32'd1);
        tick();
        serve("E_refill", 1'b0, 32'h80, 32'h0, 32'h1234_5678);
        #1;
        chk("E_hit_rdata", bus.cpu_rdata, 32'h1234_5678);

        // Make lines 3 and 15 dirty, then flush
        tick();
        set_cpu(1'b1, 1'b1, 1'b1, 32'hC, 32'h3333_3333);
        tick();
        serve("D_fill3", 1'b0, 32'hC, 32'h0, 32'h0);
        tick();
        set_cpu(1'b1, 1'b1, 1'b1, 32'h3C, 32'hFFFF_0015);
        tick();
        serve("D_fill15", 1'b0, 32'h3C, 32'h0, 32'h0);
        tick();
        set_cpu(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        chk("D_done_before", 32'(bus.flush_done), 32'd0);
        bus.flush_req = 1'b1;
        tick();
        bus.flush_req = 1'b0;
        nwr  = 0;
        done = 1'b0;
        for (int c = 0; c < 64 && !done; c++) begin
            #1;
            if (bus.flush_done) begin
                done = 1'b1;
            end else begin
                if (bus.mem_req && bus.mem_we) begin
                    if (nwr < 4) begin
                        wa[nwr] = bus.mem_addr;
                        wd[nwr] = bus.mem_wdata;
                    end
                    nwr++;
                    bus.mem_ack = 1'b1;
                end
                tick();
                bus.mem_ack = 1'b0;
            end
        end
        chk("D_flush_done", 32'(done), 32'd1);
        chk("D_flush_writes", 32'(nwr), 32'd2);
        chk("D_wr0_addr", wa[0], 32'hC);
        chk("D_wr0_data", wd[0], 32'h3333_3333);
        chk("D_wr1_addr", wa[1], 32'h3C);
        chk("D_wr1_data", wd[1], 32'hFFFF_0015);
        chk("D_after_stall", 32'(bus.cpu_stall), 32'd0);

        // flush_done survives a load hit and clears on a store
        tick();
        set_cpu(1'b1, 1'b0, 1'b1, 32'h80, 32'h0);
        #1;
        chk("F_load_rdata", bus.cpu_rdata, 32'h1234_5678);
        tick();
        #1;
        chk("F_done_after_load", 32'(bus.flush_done), 32'd1);
        set_cpu(1'b1, 1'b1, 1'b1, 32'h80, 32'h5);
        tick();
        set_cpu(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        chk("F_done_after_store", 32'(bus.flush_done), 32'd0);

        // A stray ack in IDLE is ignored and the memory data ports stay at zero
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        #1;
        chk("G_idle_mem_req", 32'(bus.mem_req), 32'd0);
        chk("G_idle_mem_we", 32'(bus.mem_we), 32'd0);
        chk("G_idle_mem_addr", bus.mem_addr, 32'h0);
        chk("G_idle_stall", 32'(bus.cpu_stall), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
